// File: rtl/tron_trail_arbiter.sv
// Tron plot responder: arbitrates two players' head-position requests, checks them against an
// on-chip occupancy map, drives the VGA pixel-write port and sweeps the arena on reset/clear.
module tron_trail_arbiter #(
  parameter int unsigned WIDTH         = 160,
  parameter int unsigned HEIGHT        = 120,
  parameter int unsigned BX0           = 10,
  parameter int unsigned BX1           = 149,
  parameter int unsigned BY0           = 17,
  parameter int unsigned BY1           = 108,
  parameter logic [2:0]  BORDER_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       a_valid,
  input  logic [7:0] a_x,
  input  logic [6:0] a_y,
  input  logic [2:0] a_colour,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_x,
  input  logic [6:0] b_y,
  input  logic [2:0] b_colour,
  output logic       b_ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       dead_a,
  output logic       dead_b,
  output logic       busy
);

  localparam int unsigned Cells = WIDTH * HEIGHT;
  localparam logic [7:0]  XLast = 8'(WIDTH - 1);
  localparam logic [6:0]  YLast = 7'(HEIGHT - 1);
  localparam logic [7:0]  XLim  = 8'(WIDTH);
  localparam logic [6:0]  YLim  = 7'(HEIGHT);
  localparam logic [7:0]  Bx0   = 8'(BX0);
  localparam logic [7:0]  Bx1   = 8'(BX1);
  localparam logic [6:0]  By0   = 7'(BY0);
  localparam logic [6:0]  By1   = 7'(BY1);

  typedef enum logic [2:0] {StSweep, StIdle, StRead, StCheck, StWrite} state_e;

  state_e      state;
  logic [7:0]  sx;
  logic [6:0]  sy;
  logic [14:0] saddr;
  logic [7:0]  req_x;
  logic [6:0]  req_y;
  logic [2:0]  req_colour;
  logic        req_b;
  logic        rr_b;
  logic        map_bit;
  logic        mem [Cells];

  logic        sweep_border;
  logic        req_in_range;
  logic        req_dead;
  logic [14:0] req_addr;
  logic        idle;
  logic        grant_b;
  logic        mem_we;
  logic        mem_wdata;
  logic [14:0] mem_waddr;

  assign sweep_border = (((sx == Bx0) || (sx == Bx1)) && (sy >= By0) && (sy <= By1)) ||
                        (((sy == By0) || (sy == By1)) && (sx >= Bx0) && (sx <= Bx1));
  assign req_in_range = (req_x < XLim) && (req_y < YLim);
  assign req_addr     = 15'(req_y) * 15'(WIDTH) + 15'(req_x);
  assign req_dead     = req_b ? dead_b : dead_a;

  // Ready is withheld while clear is sampled so no accepted request is silently lost.
  assign idle    = (state == StIdle) && !clear;
  assign grant_b = b_valid && (!a_valid || rr_b);
  assign a_ready = idle && a_valid && !grant_b;
  assign b_ready = idle && grant_b;
  assign busy    = (state == StSweep);

  assign mem_we    = !clear && ((state == StSweep) || (state == StWrite));
  assign mem_waddr = (state == StSweep) ? saddr : req_addr;
  assign mem_wdata = (state == StSweep) ? sweep_border : 1'b1;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if ((state == StRead) && req_in_range) begin
      map_bit <= mem[req_addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StSweep;
      sx         <= '0;
      sy         <= '0;
      saddr      <= '0;
      req_x      <= '0;
      req_y      <= '0;
      req_colour <= '0;
      req_b      <= 1'b0;
      rr_b       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      dead_a     <= 1'b0;
      dead_b     <= 1'b0;
    end else begin
      plot <= 1'b0;
      if (clear) begin
        state  <= StSweep;
        sx     <= '0;
        sy     <= '0;
        saddr  <= '0;
        dead_a <= 1'b0;
        dead_b <= 1'b0;
      end else begin
        case (state)
          StSweep: begin
            plot   <= 1'b1;
            x      <= sx;
            y      <= sy;
            colour <= sweep_border ? BORDER_COLOUR : 3'b000;
            saddr  <= saddr + 15'd1;
            if (sx == XLast) begin
              sx <= '0;
              if (sy == YLast) begin
                sy    <= '0;
                saddr <= '0;
                state <= StIdle;
              end else begin
                sy <= sy + 7'd1;
              end
            end else begin
              sx <= sx + 8'd1;
            end
          end
          StIdle: begin
            if (a_ready || b_ready) begin
              req_x      <= grant_b ? b_x : a_x;
              req_y      <= grant_b ? b_y : a_y;
              req_colour <= grant_b ? b_colour : a_colour;
              req_b      <= grant_b;
              rr_b       <= !grant_b;
              state      <= StRead;
            end
          end
          StRead: state <= StCheck;
          StCheck: begin
            if (!req_in_range || map_bit) begin
              if (req_b) dead_b <= 1'b1;
              else       dead_a <= 1'b1;
              state <= StIdle;
            end else if (req_dead) begin
              state <= StIdle;
            end else begin
              state <= StWrite;
            end
          end
          StWrite: begin
            plot   <= 1'b1;
            x      <= req_x;
            y      <= req_y;
            colour <= req_colour;
            state  <= StIdle;
          end
          default: state <= StSweep;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tron_trail_arbiter.sv
// Bench for tron_trail_arbiter: directed and random requests checked cycle by cycle against a
// transaction-level model (occupancy array, per-player dead flags, scheduled plot/dead events).
module tb_tron_trail_arbiter;

  logic       clk = 1'b0;
  logic       reset, clear;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_x, b_x, x;
  logic [6:0] a_y, b_y, y;
  logic [2:0] a_colour, b_colour, colour;
  logic       plot, dead_a, dead_b, busy;

  always #5 clk = ~clk;

  tron_trail_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .a_valid  (a_valid),
    .a_x      (a_x),
    .a_y      (a_y),
    .a_colour (a_colour),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_x      (b_x),
    .b_y      (b_y),
    .b_colour (b_colour),
    .b_ready  (b_ready),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .dead_a   (dead_a),
    .dead_b   (dead_b),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: cycle n is the period after the n-th rising edge since reset release.
  bit   occ [19200];
  int   m_base, m_free, m_plot_cycle, m_px, m_py, m_pc;
  bit   m_dead [2];
  int   m_dead_edge [2];
  bit   m_rr;
  bit   m_ready [2];
  bit   took [2];

  logic       d_clear;
  logic       d_v [2];
  logic [7:0] d_x [2];
  logic [6:0] d_y [2];
  logic [2:0] d_c [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit is_border(input int xx, input int yy);
    return ((xx == 10 || xx == 149) && yy >= 17 && yy <= 108) ||
           ((yy == 17 || yy == 108) && xx >= 10 && xx <= 149);
  endfunction

  task automatic model_restart(input int base);
    m_base       = base;
    m_free       = base + 19200;
    m_plot_cycle = -1;
    for (int p = 0; p < 2; p++) begin
      m_dead[p]      = 1'b0;
      m_dead_edge[p] = -1;
    end
    for (int i = 0; i < 19200; i++) occ[i] = is_border(i % 160, i / 160);
  endtask

  task automatic compare_cycle();
    int k, ex, ey, ec;
    bit ep, idle, gb;
    for (int p = 0; p < 2; p++) begin
      if (m_dead_edge[p] == cyc) begin
        m_dead[p]      = 1'b1;
        m_dead_edge[p] = -1;
      end
    end
    k  = cyc - m_base - 1;
    ep = 1'b0; ex = 0; ey = 0; ec = 0;
    if (k >= 0 && k < 19200) begin
      ep = 1'b1; ex = k % 160; ey = k / 160; ec = is_border(ex, ey) ? 7 : 0;
    end else if (cyc == m_plot_cycle) begin
      ep = 1'b1; ex = m_px; ey = m_py; ec = m_pc;
    end
    idle       = (cyc >= m_free);
    gb         = b_valid && (!a_valid || m_rr);
    m_ready[0] = idle && !clear && a_valid && !gb;
    m_ready[1] = idle && !clear && gb;
    check_eq("plot", plot, ep);
    check_eq("busy", busy, cyc < m_base + 19200);
    check_eq("dead_a", dead_a, m_dead[0]);
    check_eq("dead_b", dead_b, m_dead[1]);
    check_eq("a_ready", a_ready, m_ready[0]);
    check_eq("b_ready", b_ready, m_ready[1]);
    if (ep) begin
      check_eq("x", x, ex);
      check_eq("y", y, ey);
      check_eq("colour", colour, ec);
    end
  endtask

  task automatic model_advance();
    int p, t, rx, ry;
    took[0] = 1'b0;
    took[1] = 1'b0;
    if (clear) begin
      model_restart(cyc + 1);
    end else if (m_ready[0] || m_ready[1]) begin
      p       = m_ready[1] ? 1 : 0;
      took[p] = 1'b1;
      t       = cyc + 1;
      rx      = p ? int'(b_x) : int'(a_x);
      ry      = p ? int'(b_y) : int'(a_y);
      m_rr    = (p == 0);
      if (rx >= 160 || ry >= 120 || occ[ry * 160 + rx]) begin
        m_dead_edge[p] = t + 2;
        m_free         = t + 2;
      end else if (m_dead[p]) begin
        m_free = t + 2;
      end else begin
        occ[ry * 160 + rx] = 1'b1;
        m_plot_cycle       = t + 3;
        m_px               = rx;
        m_py               = ry;
        m_pc               = p ? int'(b_colour) : int'(a_colour);
        m_free             = t + 3;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    clear    = d_clear;
    a_valid  = d_v[0]; a_x = d_x[0]; a_y = d_y[0]; a_colour = d_c[0];
    b_valid  = d_v[1]; b_x = d_x[1]; b_y = d_y[1]; b_colour = d_c[1];
    @(negedge clk);
    compare_cycle();
    model_advance();
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic wait_sweep();
    int guard = 0;
    while (cyc < m_free && guard < 20100) begin
      step();
      guard++;
    end
    check_eq("sweep_done_busy", busy, 0);
  endtask

  task automatic send(input int p, input int xx, input int yy, input int cc);
    int guard = 0;
    d_v[p] = 1'b1; d_x[p] = 8'(xx); d_y[p] = 7'(yy); d_c[p] = 3'(cc);
    do begin
      step();
      guard++;
    end while (!took[p] && guard < 200);
    d_v[p] = 1'b0;
    if (!took[p]) check_eq("accept_timeout", p ? b_ready : a_ready, 1);
  endtask

  task automatic both(input int ax, input int ay, input int ac,
                      input int bx, input int by, input int bc);
    int guard = 0;
    bit got_a = 1'b0, got_b = 1'b0;
    d_v[0] = 1'b1; d_x[0] = 8'(ax); d_y[0] = 7'(ay); d_c[0] = 3'(ac);
    d_v[1] = 1'b1; d_x[1] = 8'(bx); d_y[1] = 7'(by); d_c[1] = 3'(bc);
    while (!(got_a && got_b) && guard < 200) begin
      step();
      guard++;
      if (took[0]) begin got_a = 1'b1; d_v[0] = 1'b0; end
      if (took[1]) begin got_b = 1'b1; d_v[1] = 1'b0; end
    end
    d_v[0] = 1'b0;
    d_v[1] = 1'b0;
    if (!got_a) check_eq("both_timeout_a", a_ready, 1);
    if (!got_b) check_eq("both_timeout_b", b_ready, 1);
  endtask

  task automatic new_random_req(input int p);
    int r;
    r      = $urandom_range(0, 15);
    d_v[p] = 1'b1;
    d_x[p] = 8'($urandom_range(9, 16));
    d_y[p] = 7'($urandom_range(16, 21));
    d_c[p] = 3'($urandom_range(0, 7));
    if (r == 0) d_x[p] = 8'($urandom_range(160, 255));
    if (r == 1) d_y[p] = 7'($urandom_range(120, 127));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clear = 1'b0;
    a_valid = 1'b0; a_x = '0; a_y = '0; a_colour = '0;
    b_valid = 1'b0; b_x = '0; b_y = '0; b_colour = '0;
    d_clear = 1'b0;
    for (int p = 0; p < 2; p++) begin
      d_v[p] = 1'b0; d_x[p] = '0; d_y[p] = '0; d_c[p] = '0;
    end
    m_rr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_restart(0);
    @(negedge clk);
    check_eq("reset_x", x, 0);
    check_eq("reset_y", y, 0);
    check_eq("reset_colour", colour, 0);
    compare_cycle();
    model_advance();
    wait_sweep();

    // Directed: single move, arbitration, out of range, clear while B is in READ.
    idle_cycles(2);
    send(0, 25, 100, 1);  idle_cycles(4);
    both(30, 30, 2, 40, 40, 3); idle_cycles(5);
    both(31, 30, 4, 41, 40, 5); idle_cycles(5);
    send(0, 160, 0, 6);   idle_cycles(3);
    send(1, 60, 60, 7);
    d_clear = 1'b1; step(); d_clear = 1'b0;
    wait_sweep();

    // Directed: cell is free again, then self/border collisions and a discarded request.
    send(0, 25, 100, 5);  idle_cycles(4);
    send(0, 25, 100, 2);  idle_cycles(4);
    send(0, 26, 100, 4);  idle_cycles(4);
    send(1, 149, 50, 3);  idle_cycles(4);
    d_clear = 1'b1; step(); d_clear = 1'b0;
    wait_sweep();

    // Random traffic in a crowded corner of the arena; stop on a request plot for async reset.
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!d_v[p] && $urandom_range(0, 2) == 0) new_random_req(p);
      end
      step();
      for (int p = 0; p < 2; p++) if (took[p]) d_v[p] = 1'b0;
      if (i >= 300 && cyc == m_plot_cycle) break;
    end

    reset = 1'b1;
    #1;
    check_eq("areset_plot", plot, 0);
    check_eq("areset_x", x, 0);
    check_eq("areset_y", y, 0);
    check_eq("areset_colour", colour, 0);
    check_eq("areset_dead_a", dead_a, 0);
    check_eq("areset_dead_b", dead_b, 0);
    check_eq("areset_busy", busy, 1);
    check_eq("areset_a_ready", a_ready, 0);
    check_eq("areset_b_ready", b_ready, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
